cp_tile_sequencer: RTL and testbench
====================================

Name: cp_tile_sequencer

Overview:
Top-level scheduler for the convolution processor (CP) core. It walks an image as channel blocks × output positions. For each block it fetches the weights once, then streams one data window per output position and collects each result. It generates the weightsPulled / dataSent / blockDone / imageDone event pulses consumed by the cpState control FSM, so that FSM is driven by a real sequencer rather than by hand.

Parameters:
DIM_W, 8, width of row/column dimension and position counters
BLK_W, 6, width of channel-block count and index

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin one image; sampled only in IDLE
img_rows  in  DIM_W  output rows for this image; latched on accepted start
img_cols  in  DIM_W  output columns; latched on accepted start
num_blocks  in  BLK_W  channel blocks; latched on accepted start
busy  out  1  high from the cycle after an accepted start until done
w_req  out  1  weight fetch request for block w_blk
w_ack  in  1  weight fetch complete
w_blk  out  BLK_W  current block index
d_req  out  1  data window request for (d_row, d_col)
d_ack  in  1  data window delivered to the core
d_row  out  DIM_W  current output row
d_col  out  DIM_W  current output column
r_valid  in  1  core result available
r_ready  out  1  result accept; high only in state RESULT
weights_pulled  out  1  1-cycle pulse on w_ack accepted
data_sent  out  1  1-cycle pulse on d_ack accepted
block_done  out  1  1-cycle pulse after the last position of a block
image_done  out  1  1-cycle pulse after the last block; also acts as done

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - All outputs 0; counters w_blk/d_row/d_col = 0.
  - Reset asserted mid-operation aborts immediately. No pulses fire in the reset cycle or the cycle after it.
- States: IDLE, WEIGHTS, DATA, RESULT, NEXT, DONE.
- IDLE:
  - On start=1, latch the three config inputs and clear counters.
  - If any latched dimension is 0, go to DONE. Otherwise go to WEIGHTS.
  - start while not in IDLE is ignored.
- WEIGHTS:
  - w_req=1, held until w_ack=1 is sampled.
  - On that edge: weights_pulled pulses next cycle, w_req drops, go to DATA.
- DATA:
  - d_req=1 with the current d_row/d_col, held until d_ack=1.
  - On that edge: data_sent pulses, go to RESULT.
- RESULT:
  - r_ready=1. On r_valid=1, the result is accepted; go to NEXT.
  - r_valid arriving in the same cycle as entry is accepted on that edge.
- NEXT (single cycle), position advance in raster order:
  - If d_col < cols-1: increment d_col, go to DATA.
  - Else if d_row < rows-1: set d_col=0, increment d_row, go to DATA.
  - Else (last position): pulse block_done. If w_blk < blocks-1, increment w_blk, clear d_row/d_col, go to WEIGHTS. Otherwise go to DONE.
- DONE: pulse image_done for one cycle, drop busy, go to IDLE.
- Latency:
  - start accepted at edge t → w_req high in cycle t+1.
  - Minimum cycles per position = 3 (DATA, RESULT, NEXT) with ack/valid returned immediately.
- Simultaneous events:
  - An ack arriving while its req is low is ignored.
  - w_ack and d_ack are never both relevant in the same state.
  - The last position's block_done and the following image_done pulse are on consecutive cycles, never the same cycle.
- Counter wrap: counters compare against latched value minus 1 and never overflow. Max config (all ones) is legal.
- Outputs d_row/d_col/w_blk are registered and stable while the corresponding req is high.

Decomposition:
- Shared package cp_pkg: state enum (IDLE, WEIGHTS, DATA, RESULT, NEXT, DONE) and the DIM_W/BLK_W defaults, reused by cpState-side logic.
- One natural sub-module: cp_pos_counter, the raster row/col counter with last-position flag, instantiated once.

Test Plan:
1. rows=2, cols=2, blocks=2, acks/valid immediate → 2 weights_pulled, 8 data_sent, positions (0,0),(0,1),(1,0),(1,1) per block, block_done ×2, image_done ×1, busy low after.
2. rows=1, cols=3, blocks=1, w_ack delayed 5 cycles → w_req held 5 cycles, weights_pulled exactly once; d_col sequence 0,1,2; image_done follows block_done by 1 cycle.
3. rows=0 (others nonzero), start → no w_req/d_req, image_done pulse in the cycle after DONE entry, busy returns 0.
4. Reset asserted while in RESULT of block 1 → next cycle all outputs 0, state IDLE. A fresh start runs cleanly from block 0.
5. start held high through an entire 1×1×1 run → exactly one image; start re-accepted only after return to IDLE.
6. r_valid high with no pending result in DATA and WEIGHTS → ignored, no state change, no spurious pulses.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared definitions for the convolution-processor tile sequencer and its cpState consumers.
package cp_pkg;

  localparam int CP_DIM_W = 8;
  localparam int CP_BLK_W = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WEIGHTS = 3'd1,
    DATA    = 3'd2,
    RESULT  = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } cp_state_e;

endpackage

// File: rtl/cp_pos_counter.sv
// Raster-order output position counter (column fastest) with a last-position flag.
module cp_pos_counter import cp_pkg::*; #(
  parameter int DIM_W = CP_DIM_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic [DIM_W-1:0] rows_m1_i,
  input  logic [DIM_W-1:0] cols_m1_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic             last_o
);

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic             col_more, row_more;

  // Bounds are stored as (size - 1) so a full-scale dimension never overflows.
  assign col_more = (col_q < cols_m1_i);
  assign row_more = (row_q < rows_m1_i);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_more) begin
        col_d = col_q + DIM_W'(1);
      end else if (row_more) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = !col_more && !row_more;

endmodule

// File: rtl/cp_tile_sequencer.sv
// IDLE wait start | WEIGHTS fetch block weights | DATA send window | RESULT collect result
// NEXT advance position/block | DONE emit image_done
module cp_tile_sequencer import cp_pkg::*; #(
  parameter int DIM_W = CP_DIM_W,
  parameter int BLK_W = CP_BLK_W
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] img_rows_i,
  input  logic [DIM_W-1:0] img_cols_i,
  input  logic [BLK_W-1:0] num_blocks_i,
  output logic             busy_o,
  output logic             w_req_o,
  input  logic             w_ack_i,
  output logic [BLK_W-1:0] w_blk_o,
  output logic             d_req_o,
  input  logic             d_ack_i,
  output logic [DIM_W-1:0] d_row_o,
  output logic [DIM_W-1:0] d_col_o,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  output logic             weights_pulled_o,
  output logic             data_sent_o,
  output logic             block_done_o,
  output logic             image_done_o
);

  cp_state_e        state_q, state_d;
  logic [DIM_W-1:0] rows_m1_q, cols_m1_q;
  logic [BLK_W-1:0] blks_m1_q, blk_q;
  logic             busy_q;
  logic             wp_q, wp_d, ds_q, ds_d, bd_q, bd_d, id_q, id_d;
  logic             accept, cfg_zero, pos_clr, pos_adv, pos_last, blk_inc;

  assign accept   = (state_q == IDLE) && start_i;
  assign cfg_zero = (img_rows_i == '0) || (img_cols_i == '0) || (num_blocks_i == '0);

  always_comb begin
    state_d = state_q;
    wp_d    = 1'b0;
    ds_d    = 1'b0;
    bd_d    = 1'b0;
    id_d    = 1'b0;
    pos_clr = 1'b0;
    pos_adv = 1'b0;
    blk_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pos_clr = 1'b1;
          state_d = cfg_zero ? DONE : WEIGHTS;
        end
      end
      WEIGHTS: begin
        if (w_ack_i) begin
          wp_d    = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        if (d_ack_i) begin
          ds_d    = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (r_valid_i) state_d = NEXT;
      end
      NEXT: begin
        if (!pos_last) begin
          pos_adv = 1'b1;
          state_d = DATA;
        end else begin
          bd_d = 1'b1;
          if (blk_q < blks_m1_q) begin
            blk_inc = 1'b1;
            pos_clr = 1'b1;
            state_d = WEIGHTS;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        id_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      rows_m1_q <= '0;
      cols_m1_q <= '0;
      blks_m1_q <= '0;
      blk_q     <= '0;
      busy_q    <= 1'b0;
      wp_q      <= 1'b0;
      ds_q      <= 1'b0;
      bd_q      <= 1'b0;
      id_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      ds_q    <= ds_d;
      bd_q    <= bd_d;
      id_q    <= id_d;
      if (accept) begin
        rows_m1_q <= img_rows_i - DIM_W'(1);
        cols_m1_q <= img_cols_i - DIM_W'(1);
        blks_m1_q <= num_blocks_i - BLK_W'(1);
        blk_q     <= '0;
        busy_q    <= 1'b1;
      end else begin
        if (state_q == DONE) busy_q <= 1'b0;
        if (blk_inc) blk_q <= blk_q + BLK_W'(1);
      end
    end
  end

  cp_pos_counter #(.DIM_W(DIM_W)) u_pos (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (pos_clr),
    .advance_i (pos_adv),
    .rows_m1_i (rows_m1_q),
    .cols_m1_i (cols_m1_q),
    .row_o     (d_row_o),
    .col_o     (d_col_o),
    .last_o    (pos_last)
  );

  assign busy_o           = busy_q;
  assign w_req_o          = (state_q == WEIGHTS);
  assign d_req_o          = (state_q == DATA);
  assign r_ready_o        = (state_q == RESULT);
  assign w_blk_o          = blk_q;
  assign weights_pulled_o = wp_q;
  assign data_sent_o      = ds_q;
  assign block_done_o     = bd_q;
  assign image_done_o     = id_q;

endmodule

// File: tb/tb_cp_tile_sequencer.sv
// Self-checking bench for cp_tile_sequencer: vector table, hand-written corner sequences, randomized runs.
module tb_cp_tile_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] img_rows = '0, img_cols = '0;
  logic [5:0] num_blocks = '0;
  logic       w_ack = 1'b0, d_ack = 1'b0, r_valid = 1'b0;
  logic       busy, w_req, d_req, r_ready;
  logic [5:0] w_blk;
  logic [7:0] d_row, d_col;
  logic       weights_pulled, data_sent, block_done, image_done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cp_tile_sequencer dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .start_i          (start),
    .img_rows_i       (img_rows),
    .img_cols_i       (img_cols),
    .num_blocks_i     (num_blocks),
    .busy_o           (busy),
    .w_req_o          (w_req),
    .w_ack_i          (w_ack),
    .w_blk_o          (w_blk),
    .d_req_o          (d_req),
    .d_ack_i          (d_ack),
    .d_row_o          (d_row),
    .d_col_o          (d_col),
    .r_valid_i        (r_valid),
    .r_ready_o        (r_ready),
    .weights_pulled_o (weights_pulled),
    .data_sent_o      (data_sent),
    .block_done_o     (block_done),
    .image_done_o     (image_done)
  );

  typedef struct {
    int rows; int cols; int blocks;
    int wd; int dd; int rd;
    bit hold;
    int exp_cyc; int exp_wreq;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int pick(input bit rnd, input int mx);
    return rnd ? int'($urandom_range(0, mx)) : mx;
  endfunction

  function automatic logic [29:0] all_out();
    return {busy, w_req, d_req, r_ready, weights_pulled, data_sent, block_done,
            image_done, w_blk, d_row, d_col};
  endfunction

  // Runs one image, serving handshakes with the given delays; compares against a
  // reference schedule built from nested block/row/col loops.
  task automatic run_image(input int rows, input int cols, input int blocks,
                           input int wd, input int dd, input int rd,
                           input bit rnd, input bit hold,
                           input int exp_cyc, input int exp_wreq, input string tag);
    int exp_q[$];
    int got_q[$];
    int wp = 0, ds = 0, bd = 0, id = 0, wreq_cyc = 0, done_idx = -1;
    int wc = 0, dc = 0, rc = 0;
    int wdl, ddl, rdl;
    bit nz, prev_dreq = 0, prev_bd = 0;
    logic [7:0] prev_r = '0, prev_c = '0;
    nz = (rows > 0) && (cols > 0) && (blocks > 0);
    if (nz)
      for (int b = 0; b < blocks; b++)
        for (int r = 0; r < rows; r++)
          for (int c = 0; c < cols; c++)
            exp_q.push_back(b * 65536 + r * 256 + c);
    wdl = pick(rnd, wd); ddl = pick(rnd, dd); rdl = pick(rnd, rd);
    @(negedge clock);
    img_rows = 8'(rows); img_cols = 8'(cols); num_blocks = 6'(blocks);
    start = 1'b1;
    for (int idx = 0; idx < 6000; idx++) begin
      @(negedge clock);
      if (!hold) start = 1'b0;
      if (idx == 0) chk({tag, ".busy_start"}, busy, 1);
      wp += int'(weights_pulled);
      ds += int'(data_sent);
      bd += int'(block_done);
      id += int'(image_done);
      if (w_req) wreq_cyc++;
      if (block_done && image_done) chk({tag, ".bd_id_same_cycle"}, 1, 0);
      if (d_req && prev_dreq && (d_row != prev_r || d_col != prev_c))
        chk({tag, ".pos_unstable"}, 1, 0);
      if (image_done) begin
        done_idx = idx;
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".bd_then_id"}, prev_bd, nz);
        start = 1'b0; w_ack = 1'b0; d_ack = 1'b0; r_valid = 1'b0;
        break;
      end
      prev_bd = block_done; prev_dreq = d_req; prev_r = d_row; prev_c = d_col;
      w_ack = 1'b0; d_ack = 1'b0; r_valid = 1'b0;
      if (w_req) begin
        if (wc >= wdl) begin w_ack = 1'b1; wc = 0; wdl = pick(rnd, wd); end
        else wc++;
      end else if (rnd) w_ack = 1'($urandom_range(0, 1));
      if (d_req) begin
        if (dc >= ddl) begin
          d_ack = 1'b1; dc = 0; ddl = pick(rnd, dd);
          got_q.push_back(int'(w_blk) * 65536 + int'(d_row) * 256 + int'(d_col));
        end else dc++;
      end else if (rnd) d_ack = 1'($urandom_range(0, 1));
      if (r_ready) begin
        if (rc >= rdl) begin r_valid = 1'b1; rc = 0; rdl = pick(rnd, rd); end
        else rc++;
      end else if (rnd) r_valid = 1'($urandom_range(0, 1));
    end
    chk({tag, ".finished"}, done_idx >= 0, 1);
    chk({tag, ".weights_pulled"}, wp, nz ? blocks : 0);
    chk({tag, ".data_sent"}, ds, exp_q.size());
    chk({tag, ".block_done"}, bd, nz ? blocks : 0);
    chk({tag, ".image_done"}, id, 1);
    chk({tag, ".npos"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] != exp_q[i]) chk({tag, ".pos"}, got_q[i], exp_q[i]);
    if (exp_cyc >= 0)  chk({tag, ".cycles"}, done_idx, exp_cyc);
    if (exp_wreq >= 0) chk({tag, ".wreq_cycles"}, wreq_cyc, exp_wreq);
    repeat (2) @(negedge clock);
    chk({tag, ".idle_after"}, {busy, w_req, d_req, image_done}, 0);
  endtask

  initial begin
    vec_t vecs[8];
    bit found;
    vecs[0] = '{2, 2, 2,   0, 0, 0, 0, 27, 2};
    vecs[1] = '{1, 3, 1,   4, 0, 0, 0, 15, 5};
    vecs[2] = '{0, 3, 2,   0, 0, 0, 0, 1,  0};
    vecs[3] = '{1, 1, 1,   0, 0, 0, 1, 5,  1};
    vecs[4] = '{3, 1, 2,   0, 1, 2, 0, 39, 2};
    vecs[5] = '{4, 2, 0,   0, 0, 0, 0, 1,  0};
    vecs[6] = '{1, 255, 1, 0, 0, 0, 0, 767, 1};
    vecs[7] = '{2, 3, 3,   2, 0, 1, 0, 82, 9};

    repeat (3) @(negedge clock);
    chk("reset_held", all_out(), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_state", all_out(), 0);

    foreach (vecs[i])
      run_image(vecs[i].rows, vecs[i].cols, vecs[i].blocks, vecs[i].wd, vecs[i].dd,
                vecs[i].rd, 1'b0, vecs[i].hold, vecs[i].exp_cyc, vecs[i].exp_wreq,
                $sformatf("vec%0d", i));

    // Abort from RESULT of block 1.
    @(negedge clock);
    img_rows = 8'd2; img_cols = 8'd2; num_blocks = 6'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (r_ready && w_blk == 6'd1) begin found = 1'b1; break; end
      w_ack = w_req; d_ack = d_req; r_valid = r_ready;
      @(negedge clock);
    end
    w_ack = 1'b0; d_ack = 1'b0; r_valid = 1'b0;
    chk("abort.reach_result_blk1", found, 1);
    @(negedge clock);
    chk("abort.still_result", r_ready, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort.outputs_cleared", all_out(), 0);
    @(negedge clock);
    chk("abort.no_pulse_after", all_out(), 0);
    run_image(1, 1, 1, 0, 0, 0, 1'b0, 1'b0, 5, 1, "post_abort");

    // Stray handshakes outside their owning state.
    @(negedge clock);
    img_rows = 8'd1; img_cols = 8'd1; num_blocks = 6'd1; start = 1'b1;
    @(negedge clock);
    start = 1'b0; r_valid = 1'b1; d_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stray.w_state_req", w_req, 1);
      chk("stray.w_state_quiet", {d_req, r_ready, weights_pulled, data_sent, block_done, image_done}, 0);
    end
    d_ack = 1'b0; w_ack = 1'b1;
    @(negedge clock);
    chk("stray.wp_pulse", {weights_pulled, d_req}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stray.d_state_req", d_req, 1);
      chk("stray.d_state_quiet", {w_req, r_ready, weights_pulled, data_sent, block_done, image_done}, 0);
    end
    w_ack = 1'b0; d_ack = 1'b1;
    @(negedge clock);
    d_ack = 1'b0;
    chk("stray.result_entry", {data_sent, r_ready}, 2'b11);
    @(negedge clock);
    r_valid = 1'b0;
    chk("stray.next_state", {r_ready, d_req, w_req}, 0);
    @(negedge clock);
    chk("stray.block_done", block_done, 1);
    @(negedge clock);
    chk("stray.image_done", {image_done, busy}, 2'b10);

    // Randomized images with random latencies and stray acks when idle.
    for (int k = 0; k < 12; k++)
      run_image(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                3, 3, 3, 1'b1, 1'b0, -1, -1, $sformatf("rnd%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
